freq_meter: RTL



---
 rtl/freq_meter_if.sv | 20 ++
 rtl/freq_meter.sv | 123 ++++++++++++
 2 files changed

// File: rtl/freq_meter_if.sv
// freq_meter_if: measurement bus of the gated frequency meter.
//   En, SigIn, Gate : driven by the controlling side (master)
//   Count [N-1:0]   : edge count of the last completed gate interval
//   Valid           : one-cycle strobe when Count/Ovf update
//   Ovf             : last completed interval saturated
//   Busy            : meter is measuring (state MEAS)
interface freq_meter_if #(
  parameter int N = 24
);
  logic         En;
  logic         SigIn;
  logic         Gate;
  logic [N-1:0] Count;
  logic         Valid;
  logic         Ovf;
  logic         Busy;

  modport master (output En, SigIn, Gate, input Count, Valid, Ovf, Busy);
  modport slave  (input En, SigIn, Gate, output Count, Valid, Ovf, Busy);
endinterface

// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of the asynchronous SigIn between
// consecutive rising edges of the asynchronous Gate, in the ClkIn domain.
// Each completed interval is published on bus.Count/bus.Ovf with a
// one-cycle bus.Valid strobe.
//   ClkIn : system clock, all state changes on its rising edge
//   Clr_  : asynchronous active-low clear of every register
//   bus   : freq_meter_if slave (En, SigIn, Gate in; Count, Valid, Ovf, Busy out)
module freq_meter #(
  parameter int N = 24
) (
  input  logic         ClkIn,
  input  logic         Clr_,
  freq_meter_if.slave  bus
);

  typedef enum logic {IDLE, MEAS} state_e;

  localparam logic [N-1:0] ONE = N'(1);

  state_e       state_q, state_d;
  logic [2:0]   sig_sync_q, sig_sync_d;    // [0]=s1, [1]=s2, [2]=s3
  logic [2:0]   gate_sync_q, gate_sync_d;
  logic [1:0]   settle_q, settle_d;
  logic         gate_arm_q, gate_arm_d;
  logic [N-1:0] acc_q, acc_d;
  logic         sat_q, sat_d;
  logic [N-1:0] count_q, count_d;
  logic         ovf_q, ovf_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;

  logic s_edge;
  logic g_edge;

  assign s_edge = sig_sync_q[1] & ~sig_sync_q[2];
  // A Gate that is already high when the clear is released must not look
  // like a rising edge: gate_arm_q only sets once s2 holds a real sample
  // (settle_q full) and that sample is low.
  assign g_edge = gate_sync_q[1] & ~gate_sync_q[2] & gate_arm_q;

  always_comb begin
    // NOTE: every _d gets a default here so no path leaves it unassigned;
    // a missing default would infer a latch.
    state_d     = state_q;
    acc_d       = acc_q;
    sat_d       = sat_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    valid_d     = 1'b0;

    sig_sync_d  = {sig_sync_q[1:0], bus.SigIn};
    gate_sync_d = {gate_sync_q[1:0], bus.Gate};
    settle_d    = {settle_q[0], 1'b1};
    gate_arm_d  = gate_arm_q | (settle_q[1] & ~gate_sync_q[1]);

    unique case (state_q)
      IDLE: begin
        // The interval in progress when enabled is partial, so counting
        // only starts at the first gate edge seen while enabled.
        acc_d = '0;
        sat_d = 1'b0;
        if (bus.En && g_edge) state_d = MEAS;
      end
      MEAS: begin
        if (!bus.En) begin
          // Disable wins over a coincident gate edge; that interval is lost.
          state_d = IDLE;
          acc_d   = '0;
          sat_d   = 1'b0;
        end else if (g_edge) begin
          count_d = acc_q;
          ovf_d   = sat_q;
          valid_d = 1'b1;
          // A signal edge in the boundary cycle belongs to the new interval.
          acc_d   = s_edge ? ONE : '0;
          sat_d   = 1'b0;
        end else if (s_edge) begin
          if (&acc_q) sat_d = 1'b1;
          else        acc_d = acc_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == MEAS);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the values from before this clock edge.
  always_ff @(posedge ClkIn or negedge Clr_) begin
    if (!Clr_) begin
      state_q     <= IDLE;
      sig_sync_q  <= '0;
      gate_sync_q <= '0;
      settle_q    <= '0;
      gate_arm_q  <= 1'b0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sig_sync_q  <= sig_sync_d;
      gate_sync_q <= gate_sync_d;
      settle_q    <= settle_d;
      gate_arm_q  <= gate_arm_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.Count = count_q;
  assign bus.Ovf   = ovf_q;
  assign bus.Valid = valid_q;
  assign bus.Busy  = busy_q;

endmodule
